// File: rtl/cursor_pkg.sv
// Shared types for the cursor bitmap RAM writer: command opcodes and FSM states.
package cursor_pkg;

    typedef enum logic [1:0] {
        WRITE = 2'b00,
        FILL  = 2'b01,
        LOAD  = 2'b10,
        NOP   = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_LOAD = 2'b10
    } state_e;

endpackage

// File: rtl/cursor_ram_writer.sv
// Turns WRITE/FILL/LOAD/NOP commands into a registered RAM write port (we/addr_w/din) with a done pulse.
// Latency 1 cycle from handshake to write; commands stall while busy, LOAD pixels stall via pix_ready.
module cursor_ram_writer
    import cursor_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  abort,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   fill_dat_q, fill_dat_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        rem_d      = rem_q;
        fill_dat_d = fill_dat_q;
        we_d       = 1'b0;
        addr_w_d   = addr_w_q;
        din_d      = din_q;
        done_d     = 1'b0;
        cmd_ready  = (state_q == ST_IDLE);
        pix_ready  = (state_q == ST_LOAD) && (rem_q != '0) && !abort;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        WRITE: begin
                            we_d     = 1'b1;
                            addr_w_d = cmd_addr;
                            din_d    = cmd_data;
                            done_d   = 1'b1;
                        end
                        FILL: begin
                            // Address 0 is written straight from the accept cycle; the counter resumes at 1.
                            state_d    = ST_FILL;
                            fill_dat_d = cmd_data;
                            we_d       = 1'b1;
                            addr_w_d   = '0;
                            din_d      = cmd_data;
                            addr_cnt_d = ADDR_WIDTH'(1);
                        end
                        LOAD: begin
                            if (cmd_len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d    = ST_LOAD;
                                rem_d      = cmd_len;
                                addr_cnt_d = cmd_addr;
                            end
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_FILL: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    addr_cnt_d = '0;
                end else begin
                    we_d       = 1'b1;
                    addr_w_d   = addr_cnt_q;
                    din_d      = fill_dat_q;
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    if (addr_cnt_q == ADDR_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    rem_d      = '0;
                    addr_cnt_d = '0;
                end else if (pix_valid && pix_ready) begin
                    // Counter wraps naturally at the top of the bitmap.
                    we_d       = 1'b1;
                    addr_w_d   = addr_cnt_q;
                    din_d      = pix_data;
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == (ADDR_WIDTH+1)'(1)) begin
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        addr_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            rem_q      <= '0;
            fill_dat_q <= '0;
            we_q       <= 1'b0;
            addr_w_q   <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            rem_q      <= rem_d;
            fill_dat_q <= fill_dat_d;
            we_q       <= we_d;
            addr_w_q   <= addr_w_d;
            din_q      <= din_d;
            done_q     <= done_d;
        end
    end

    assign busy   = !cmd_ready;
    assign we     = we_q;
    assign addr_w = addr_w_q;
    assign din    = din_q;
    assign done   = done_q;

endmodule

// File: tb/tb_cursor_ram_writer.sv
// Randomized and directed bench for cursor_ram_writer against a transaction-level model.
module tb_cursor_ram_writer;

    localparam int AW    = 10;
    localparam int DW    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [AW:0]   cmd_len;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          abort;
    logic          we;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 fill, 2 load; idx = writes done so far in the current op.
    int m_mode = 0;
    int m_idx, m_n, m_base, m_val;
    int e_we, e_done, e_addr, e_din;

    cursor_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .abort(abort), .we(we), .addr_w(addr_w), .din(din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        e_we = 0; e_done = 0; e_addr = 0; e_din = 0;
        if (m_mode == 0) begin
            if (cmd_valid) begin
                case (cmd_op)
                    2'b00: begin e_we = 1; e_addr = cmd_addr; e_din = cmd_data; e_done = 1; end
                    2'b11: e_done = 1;
                    2'b01: begin
                        m_mode = 1; m_val = cmd_data; m_idx = 1;
                        e_we = 1; e_addr = 0; e_din = cmd_data;
                    end
                    default: begin
                        if (cmd_len == 0) e_done = 1;
                        else begin m_mode = 2; m_n = cmd_len; m_base = cmd_addr; m_idx = 0; end
                    end
                endcase
            end
        end else if (abort) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            e_we = 1; e_addr = m_idx; e_din = m_val;
            m_idx++;
            if (m_idx == DEPTH) begin e_done = 1; m_mode = 0; end
        end else if (pix_valid) begin
            e_we = 1; e_addr = (m_base + m_idx) % DEPTH; e_din = pix_data;
            m_idx++;
            if (m_idx == m_n) begin e_done = 1; m_mode = 0; end
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks the cycle and the edge that ends it.
    task automatic step();
        #1;
        chk("cmd_ready", cmd_ready, m_mode == 0);
        chk("busy", busy, m_mode != 0);
        chk("pix_ready", pix_ready, (m_mode == 2) && !abort);
        model_step();
        @(posedge clk);
        #1;
        chk("we", we, e_we);
        chk("done", done, e_done);
        if (e_we != 0) begin
            chk("addr_w", addr_w, e_addr);
            chk("din", din, e_din);
        end
    endtask

    task automatic issue(input logic [1:0] op, input int a, input int d, input int len);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(a); cmd_data = DW'(d); cmd_len = (AW+1)'(len);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input string tag);
        int g;
        g = 0;
        while (m_mode != 0 && g < 3000) begin
            step();
            g++;
        end
        if (m_mode != 0) chk({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = '0; cmd_data = '0;
        cmd_len = '0; pix_valid = 1'b0; pix_data = '0; abort = 1'b0;
        #12;
        chk("rst_we", we, 0);
        chk("rst_addr_w", addr_w, 0);
        chk("rst_din", din, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pix_ready", pix_ready, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(2'b00, 'h155, 1, 0);
        step();
        issue(2'b11, 0, 0, 0);

        issue(2'b01, 0, 0, 0);
        run_until_idle("fill");
        step();

        issue(2'b10, 'h3FE, 0, 4);
        pix_valid = 1'b1; pix_data = 1'b1; step();
        pix_data = 1'b0; step();
        pix_valid = 1'b0; step();
        pix_valid = 1'b1; pix_data = 1'b1; step();
        step();
        pix_valid = 1'b0; step();

        issue(2'b10, 'h20, 0, 0);
        step();

        issue(2'b01, 0, 1, 0);
        repeat (9) step();
        abort = 1'b1; step();
        abort = 1'b0; step(); step();

        issue(2'b10, 'h100, 0, 8);
        pix_valid = 1'b1; pix_data = 1'b1; step(); step();
        reset_n = 1'b0;
        #1;
        chk("arst_we", we, 0);
        chk("arst_pix_ready", pix_ready, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_done", done, 0);
        chk("arst_addr_w", addr_w, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_mode = 0;
        @(posedge clk);
        #1;
        chk("post_rst_we", we, 0);
        step();
        pix_valid = 1'b0;

        for (int i = 0; i < 8000; i++) begin
            cmd_valid = 1'($urandom % 2);
            cmd_op    = 2'($urandom % 4);
            if (cmd_op == 2'b01 && ($urandom % 16) != 0) cmd_op = 2'b00;
            cmd_addr  = AW'($urandom);
            cmd_data  = DW'($urandom);
            cmd_len   = (($urandom % 4) == 0) ? (AW+1)'($urandom_range(0, DEPTH))
                                              : (AW+1)'($urandom_range(0, 8));
            pix_valid = ($urandom % 4) != 0;
            pix_data  = DW'($urandom);
            abort     = ($urandom % 64) == 0;
            step();
        end
        cmd_valid = 1'b0; abort = 1'b0; pix_valid = 1'b1;
        run_until_idle("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
